// File: rtl/cpu_control.sv
// LITE-16 multi-cycle sequencer: fetch, decode, execute, memory and write-back control.
// All outputs are registered from the next-state decode, so they change exactly on state entry.
module cpu_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ready,
    input  logic [15:0] imem_data,
    input  logic        alu_cmp,
    output logic [15:0] pc,
    output logic        imem_re,
    output logic [2:0]  alu_codeop,
    output logic        alu_ri,
    output logic        alu_ld,
    output logic        alu_fn,
    output logic [15:0] imm16,
    output logic [2:0]  rf_ra,
    output logic [2:0]  rf_rb,
    output logic [2:0]  rf_rd,
    output logic        rf_we,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0]  codeop;
        logic        ri;
        logic        fn;
        logic [15:0] imm;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rd;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (ir[15:14])
            2'b00: begin
                c.codeop = ir[13:11];
                c.rd     = ir[10:8];
                c.ra     = ir[7:5];
                c.rb     = ir[4:2];
                c.fn     = ir[0];
                c.ri     = 1'b0;
            end
            2'b01: begin
                c.codeop = ir[13:11];
                c.rd     = ir[10:8];
                c.ra     = ir[7:5];
                c.rb     = ir[4:2];
                c.imm    = {{11{ir[4]}}, ir[4:0]};
                c.ri     = 1'b1;
                c.fn     = 1'b0;
            end
            2'b10: begin
                c.codeop = 3'b000;
                c.ri     = 1'b1;
                c.ra     = ir[7:5];
                c.imm    = {{11{ir[4]}}, ir[4:0]};
                // A store reads its data register through port B; a load writes it.
                if (ir[13]) begin
                    c.rb = ir[10:8];
                end else begin
                    c.rd = ir[10:8];
                end
            end
            2'b11: begin
                if (!ir[13]) begin
                    c.codeop = 3'b111;
                    c.ra     = ir[7:5];
                    c.rb     = ir[4:2];
                    c.imm    = {{11{ir[12]}}, ir[12:8]};
                end else begin
                    c = '0;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] ir_r;
    logic [15:0] ir_nx_s;
    logic [15:0] pc_nx_s;
    logic [15:0] br_off_s;
    logic        is_nop_s;
    logic        is_halt_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        active_s;
    ctrl_t       ctrl_s;

    assign is_nop_s   = (ir_r[15:12] == 4'b1110);
    assign is_halt_s  = (ir_r[15:12] == 4'b1111);
    assign is_load_s  = (ir_r[15:13] == 3'b100);
    assign is_store_s = (ir_r[15:13] == 3'b101);
    assign br_off_s   = {{11{ir_r[12]}}, ir_r[12:8]};
    assign ctrl_s     = decode_ctrl(ir_r);
    assign active_s   = (state_nx_s == ST_EXEC) || (state_nx_s == ST_MEM) || (state_nx_s == ST_WB);

    // Next-state, instruction register and program counter sequencing.
    always_comb begin
        state_nx_s = state_r;
        ir_nx_s    = ir_r;
        pc_nx_s    = pc;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_nx_s    = imem_data;
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                pc_nx_s = pc + 16'd1;
                if (is_nop_s) begin
                    state_nx_s = ST_FETCH;
                end else if (is_halt_s) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!ir_r[15]) begin
                    state_nx_s = ST_WB;
                end else if (!ir_r[14]) begin
                    state_nx_s = ST_MEM;
                end else begin
                    // Only conditional branches reach EXEC from the control class.
                    if (alu_cmp) begin
                        pc_nx_s = pc + br_off_s;
                    end else begin
                        pc_nx_s = pc;
                    end
                    state_nx_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    state_nx_s = ST_MEM;
                end else if (ir_r[13]) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_WB;
                end
            end
            ST_WB:   state_nx_s = ST_FETCH;
            ST_HALT: state_nx_s = ST_HALT;
            default: state_nx_s = ST_FETCH;
        endcase
    end

    // State, program counter and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            ir_r       <= 16'h0000;
            pc         <= 16'h0000;
            imem_re    <= 1'b0;
            alu_codeop <= 3'b000;
            alu_ri     <= 1'b0;
            alu_ld     <= 1'b0;
            alu_fn     <= 1'b0;
            imm16      <= 16'h0000;
            rf_ra      <= 3'b000;
            rf_rb      <= 3'b000;
            rf_rd      <= 3'b000;
            rf_we      <= 1'b0;
            dmem_re    <= 1'b0;
            dmem_we    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ir_r    <= ir_nx_s;
            pc      <= pc_nx_s;
            imem_re <= (state_nx_s == ST_FETCH);
            if (active_s) begin
                alu_codeop <= ctrl_s.codeop;
                alu_ri     <= ctrl_s.ri;
                alu_fn     <= ctrl_s.fn;
                imm16      <= ctrl_s.imm;
                rf_ra      <= ctrl_s.ra;
                rf_rb      <= ctrl_s.rb;
                rf_rd      <= ctrl_s.rd;
            end else begin
                alu_codeop <= 3'b000;
                alu_ri     <= 1'b0;
                alu_fn     <= 1'b0;
                imm16      <= 16'h0000;
                rf_ra      <= 3'b000;
                rf_rb      <= 3'b000;
                rf_rd      <= 3'b000;
            end
            alu_ld  <= (state_nx_s == ST_WB) && is_load_s;
            rf_we   <= (state_nx_s == ST_WB);
            dmem_re <= (state_nx_s == ST_MEM) && is_load_s;
            dmem_we <= (state_nx_s == ST_MEM) && is_store_s;
            halted  <= (state_nx_s == ST_HALT);
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: instruction-level reference model checked every cycle,
// plus hand-computed cycle/pc expectations for the directed programs.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ready = 1'b0;
    logic        alu_cmp = 1'b0;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic        imem_re;
    logic [2:0]  alu_codeop;
    logic        alu_ri;
    logic        alu_ld;
    logic        alu_fn;
    logic [15:0] imm16;
    logic [2:0]  rf_ra;
    logic [2:0]  rf_rb;
    logic [2:0]  rf_rd;
    logic        rf_we;
    logic        dmem_re;
    logic        dmem_we;
    logic        halted;

    cpu_control dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .imem_data(imem_data), .alu_cmp(alu_cmp),
        .pc(pc), .imem_re(imem_re), .alu_codeop(alu_codeop), .alu_ri(alu_ri), .alu_ld(alu_ld),
        .alu_fn(alu_fn), .imm16(imm16), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rd(rf_rd),
        .rf_we(rf_we), .dmem_re(dmem_re), .dmem_we(dmem_we), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] prog [0:15];
    logic [15:0] hi_word;
    assign imem_data = (pc == 16'hFFFF) ? hi_word : prog[pc[3:0]];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sval5(input logic [4:0] v);
        return v[4] ? int'(v) - 32 : int'(v);
    endfunction

    // Reference model: phase of the current instruction plus architectural pc/ir.
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;
    int          m_phase = P_F;
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_ir = 16'h0000;
    logic        m_fresh = 1'b1;
    int          cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_F;
            m_pc    <= 16'h0000;
            m_ir    <= 16'h0000;
            m_fresh <= 1'b1;
            cyc     <= 0;
        end else begin
            m_fresh <= 1'b0;
            cyc     <= cyc + 1;
            case (m_phase)
                P_F: if (mem_ready) begin m_ir <= imem_data; m_phase <= P_D; end
                P_D: begin
                    m_pc <= m_pc + 16'd1;
                    if (m_ir[15:12] == 4'hE)      m_phase <= P_F;
                    else if (m_ir[15:12] == 4'hF) m_phase <= P_H;
                    else                          m_phase <= P_E;
                end
                P_E: begin
                    if (m_ir[15:14] == 2'b11) begin
                        if (alu_cmp) m_pc <= 16'(int'(m_pc) + sval5(m_ir[12:8]));
                        m_phase <= P_F;
                    end else if (m_ir[15:14] == 2'b10) begin
                        m_phase <= P_M;
                    end else begin
                        m_phase <= P_W;
                    end
                end
                P_M: if (mem_ready) m_phase <= m_ir[13] ? P_F : P_W;
                P_W: m_phase <= P_F;
                default: m_phase <= m_phase;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [15:0] e_op, e_ri, e_fn, e_imm, e_ra, e_rb, e_rd;
        logic        act, is_ld, is_st;
        e_op = 0; e_ri = 0; e_fn = 0; e_imm = 0; e_ra = 0; e_rb = 0; e_rd = 0;
        act   = (m_phase == P_E) || (m_phase == P_M) || (m_phase == P_W);
        is_ld = (m_ir[15:13] == 3'b100);
        is_st = (m_ir[15:13] == 3'b101);
        if (act) begin
            if (!m_ir[15]) begin
                e_op = 16'(m_ir[13:11]); e_rd = 16'(m_ir[10:8]);
                e_ra = 16'(m_ir[7:5]);   e_rb = 16'(m_ir[4:2]);
                e_ri = 16'(m_ir[14]);
                e_fn = m_ir[14] ? 16'd0 : 16'(m_ir[0]);
                e_imm = m_ir[14] ? 16'(sval5(m_ir[4:0])) : 16'd0;
            end else if (!m_ir[14]) begin
                e_ri = 16'd1; e_ra = 16'(m_ir[7:5]);
                e_imm = 16'(sval5(m_ir[4:0]));
                if (is_st) e_rb = 16'(m_ir[10:8]);
                else       e_rd = 16'(m_ir[10:8]);
            end else begin
                e_op = 16'd7; e_ra = 16'(m_ir[7:5]); e_rb = 16'(m_ir[4:2]);
                e_imm = 16'(sval5(m_ir[12:8]));
            end
        end
        check("pc", pc, m_pc);
        check("imem_re", 16'(imem_re), 16'((m_phase == P_F) && !m_fresh));
        check("codeop", 16'(alu_codeop), e_op);
        check("ri", 16'(alu_ri), e_ri);
        check("fn", 16'(alu_fn), e_fn);
        check("imm16", imm16, e_imm);
        check("rf_ra", 16'(rf_ra), e_ra);
        check("rf_rb", 16'(rf_rb), e_rb);
        check("rf_rd", 16'(rf_rd), e_rd);
        check("alu_ld", 16'(alu_ld), 16'((m_phase == P_W) && is_ld));
        check("rf_we", 16'(rf_we), 16'(m_phase == P_W));
        check("dmem_re", 16'(dmem_re), 16'((m_phase == P_M) && is_ld));
        check("dmem_we", 16'(dmem_we), 16'((m_phase == P_M) && is_st));
        check("halted", 16'(halted), 16'(m_phase == P_H));
    end

    int ld_stalls = 0;
    int f_stalls = 0;
    int br_cnt = 0;
    int n_re = 0;
    int n_we = 0;

    task automatic drive();
        mem_ready = 1'b1;
        if (m_phase == P_M && m_ir == 16'h8125 && ld_stalls < 3) begin
            mem_ready = 1'b0;
            ld_stalls++;
        end else if (m_phase == P_F && m_pc == 16'd1 && f_stalls < 2) begin
            mem_ready = 1'b0;
            f_stalls++;
        end
        if (m_phase == P_E && m_ir[15:13] == 3'b110) begin
            alu_cmp = (br_cnt % 2 == 0);
            br_cnt++;
        end else begin
            alu_cmp = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #4;
        if (dmem_re) n_re++;
        if (rf_we) n_we++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        alu_cmp = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_imem_re", 16'(imem_re), 16'd0);
        check("rst_rf_we", 16'(rf_we), 16'd0);
        check("rst_codeop", 16'(alu_codeop), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        rst = 1'b0;
        drive();
        #4;
        n_re = 0;
        n_we = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 16'hE000;
        hi_word = 16'hE000;
        prog[0] = 16'h0B14;
        prog[1] = 16'h43FF;
        prog[2] = 16'h8125;
        prog[3] = 16'hA234;
        prog[4] = 16'hE000;
        prog[5] = 16'hDE28;
        prog[6] = 16'hF000;

        do_reset();
        check("c0_pc", pc, 16'h0000);
        run_to(2);
        check("alu_exec_pc", pc, 16'h0001);
        check("alu_exec_codeop", 16'(alu_codeop), 16'd1);
        check("alu_exec_ri", 16'(alu_ri), 16'd0);
        check("alu_exec_rd", 16'(rf_rd), 16'd3);
        check("alu_exec_rb", 16'(rf_rb), 16'd5);
        run_to(3);
        check("alu_wb_we", 16'(rf_we), 16'd1);
        run_to(4);
        check("alu_we_count", 16'(n_we), 16'd1);
        run_to(8);
        check("imm_exec_imm", imm16, 16'hFFFF);
        check("imm_exec_ri", 16'(alu_ri), 16'd1);
        run_to(9);
        check("imm_wb_imm", imm16, 16'hFFFF);
        check("imm_wb_ri", 16'(alu_ri), 16'd1);
        run_to(17);
        check("ld_re_cycles", 16'(n_re), 16'd4);
        check("ld_wb_ld", 16'(alu_ld), 16'd1);
        check("ld_wb_we", 16'(rf_we), 16'd1);
        run_to(18);
        check("ld_done_fetch", 16'(imem_re), 16'd1);
        check("ld_done_pc", pc, 16'h0003);
        run_to(27);
        check("br_taken_pc", pc, 16'h0004);
        run_to(32);
        check("br_not_taken_pc", pc, 16'h0006);
        run_to(34);
        check("halt_flag", 16'(halted), 16'd1);
        check("halt_pc", pc, 16'h0007);
        run_to(40);
        check("halt_stay", 16'(halted), 16'd1);
        check("halt_pc_frozen", pc, 16'h0007);

        prog[0] = 16'hDE00;
        prog[1] = 16'h0B14;
        do_reset();
        run_to(3);
        check("wrap_br_pc", pc, 16'hFFFF);
        run_to(5);
        check("wrap_nop_pc", pc, 16'h0000);
        run_to(8);
        check("after_wrap_pc", pc, 16'h0001);
        run_to(11);
        check("wb_before_rst", 16'(rf_we), 16'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wb_we", 16'(rf_we), 16'd0);
        check("rst_mid_wb_pc", pc, 16'h0000);
        do_reset();
        run_to(2);
        check("restart_pc", pc, 16'h0001);
        check("restart_codeop", 16'(alu_codeop), 16'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
